punc_debug_dumper: RTL and testbench

Sequential host-side reader for the PUnC debug ports. On a start pulse it walks the PC, then R0–R7, then a parameterised memory window through `rf_debug_addr` / `mem_debug_addr`. It streams each captured word out over a valid/ready interface with a source tag, for use by the bench, a UART bridge or a trace buffer. It sits beside the PUnC top level and drives only its debug address inputs. It never stalls or modifies the processor, so a dump is non-atomic with respect to a running program.

---
 rtl/punc_debug_dumper.sv | 149 ++++++++++++++
 tb/tb_punc_debug_dumper.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/punc_debug_dumper.sv
// punc_debug_dumper: walks PC, R0-R7 and a memory window through the PUnC
// debug ports and streams every captured word out over valid/ready.
module punc_debug_dumper #(
    parameter logic [15:0] MEM_BASE  = 16'h0000,
    parameter int unsigned MEM_WORDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [2:0]  rf_debug_addr,
    output logic [15:0] mem_debug_addr,
    input  logic [15:0] pc_debug_data,
    input  logic [15:0] rf_debug_data,
    input  logic [15:0] mem_debug_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic [1:0]  out_tag,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PC,
        S_RF,
        S_MEM
    } state_t;

    localparam logic [1:0]  TAG_PC  = 2'd0;
    localparam logic [1:0]  TAG_RF  = 2'd1;
    localparam logic [1:0]  TAG_MEM = 2'd2;
    localparam logic [16:0] WORDS   = 17'(MEM_WORDS);
    localparam bit          HAS_MEM = (MEM_WORDS != 0);

    state_t      state;
    logic [16:0] mem_cnt;
    logic        rf_end;
    logic        mem_end;

    // Last-item flags for the register and memory walks.
    always_comb begin
        rf_end  = (rf_debug_addr == 3'd7);
        mem_end = (mem_cnt == WORDS - 17'd1);
    end

    // Dump sequencer: each active state alternates SAMPLE (!out_valid)
    // and HOLD (out_valid) until the consumer takes the word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= S_IDLE;
            mem_cnt        <= 17'd0;
            rf_debug_addr  <= 3'd0;
            mem_debug_addr <= 16'h0000;
            out_valid      <= 1'b0;
            out_data       <= 16'h0000;
            out_tag        <= 2'd0;
            out_last       <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_PC;
                        busy           <= 1'b1;
                        rf_debug_addr  <= 3'd0;
                        mem_debug_addr <= MEM_BASE;
                        mem_cnt        <= 17'd0;
                        out_last       <= 1'b0;
                    end
                end
                S_PC: begin
                    if (!out_valid) begin
                        out_data  <= pc_debug_data;
                        out_tag   <= TAG_PC;
                        out_last  <= 1'b0;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid     <= 1'b0;
                        state         <= S_RF;
                        rf_debug_addr <= 3'd0;
                    end
                end
                S_RF: begin
                    if (!out_valid) begin
                        out_data  <= rf_debug_data;
                        out_tag   <= TAG_RF;
                        out_last  <= rf_end && !HAS_MEM;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!rf_end) begin
                            rf_debug_addr <= rf_debug_addr + 3'd1;
                        end else if (HAS_MEM) begin
                            state <= S_MEM;
                        end else begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            out_last <= 1'b0;
                        end
                    end
                end
                S_MEM: begin
                    if (!out_valid) begin
                        out_data  <= mem_debug_data;
                        out_tag   <= TAG_MEM;
                        out_last  <= mem_end;
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        if (!mem_end) begin
                            mem_debug_addr <= mem_debug_addr + 16'd1;
                            mem_cnt        <= mem_cnt + 17'd1;
                        end else begin
                            state    <= S_IDLE;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            out_last <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // A presented word stays put until the consumer accepts it.
    property p_hold;
        @(posedge clk) disable iff (!rst)
            (out_valid && !out_ready) |=>
                (out_valid && $stable(out_data) &&
                 $stable(out_tag) && $stable(out_last));
    endproperty
    a_hold: assert property (p_hold);

    // Output activity only while a dump is in progress.
    property p_busy;
        @(posedge clk) disable iff (!rst)
            out_valid |-> busy;
    endproperty
    a_busy: assert property (p_busy);

endmodule

// File: tb/tb_punc_debug_dumper.sv
// Scoreboard bench for punc_debug_dumper: three instances cover the
// default window, a wrapping window and the memory-less dump.
module tb_punc_debug_dumper;

    typedef struct packed {
        logic [1:0]  tag;
        logic        last;
        logic [15:0] data;
        logic [15:0] addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start [3];
    logic        ready [3];
    logic [2:0]  rfa   [3];
    logic [15:0] mema  [3];
    logic [15:0] rfd   [3];
    logic [15:0] memd  [3];
    logic        ov    [3];
    logic [15:0] od    [3];
    logic [1:0]  ot    [3];
    logic        ol    [3];
    logic        bz    [3];
    logic        dn    [3];

    logic [15:0] pc_v;
    logic [15:0] rf_m  [8];
    logic [15:0] mem_m [65536];

    exp_t        sq    [3][$];
    int          stall [3];
    logic        hold_v[3];
    logic [19:0] held  [3];

    int errors = 0;
    int checks = 0;

    int          nwords [3];
    logic [15:0] bases  [3];

    always #5 clk = ~clk;

    assign rfd[0]  = rf_m[rfa[0]];
    assign rfd[1]  = rf_m[rfa[1]];
    assign rfd[2]  = rf_m[rfa[2]];
    assign memd[0] = mem_m[mema[0]];
    assign memd[1] = mem_m[mema[1]];
    assign memd[2] = mem_m[mema[2]];

    punc_debug_dumper #(.MEM_BASE(16'h0000), .MEM_WORDS(16)) u0 (
        .clk(clk), .rst(rst), .start(start[0]),
        .rf_debug_addr(rfa[0]), .mem_debug_addr(mema[0]),
        .pc_debug_data(pc_v), .rf_debug_data(rfd[0]),
        .mem_debug_data(memd[0]),
        .out_valid(ov[0]), .out_ready(ready[0]), .out_data(od[0]),
        .out_tag(ot[0]), .out_last(ol[0]), .busy(bz[0]), .done(dn[0])
    );

    punc_debug_dumper #(.MEM_BASE(16'hFFFE), .MEM_WORDS(4)) u1 (
        .clk(clk), .rst(rst), .start(start[1]),
        .rf_debug_addr(rfa[1]), .mem_debug_addr(mema[1]),
        .pc_debug_data(pc_v), .rf_debug_data(rfd[1]),
        .mem_debug_data(memd[1]),
        .out_valid(ov[1]), .out_ready(ready[1]), .out_data(od[1]),
        .out_tag(ot[1]), .out_last(ol[1]), .busy(bz[1]), .done(dn[1])
    );

    punc_debug_dumper #(.MEM_BASE(16'h1234), .MEM_WORDS(0)) u2 (
        .clk(clk), .rst(rst), .start(start[2]),
        .rf_debug_addr(rfa[2]), .mem_debug_addr(mema[2]),
        .pc_debug_data(pc_v), .rf_debug_data(rfd[2]),
        .mem_debug_data(memd[2]),
        .out_valid(ov[2]), .out_ready(ready[2]), .out_data(od[2]),
        .out_tag(ot[2]), .out_last(ol[2]), .busy(bz[2]), .done(dn[2])
    );

    task automatic chk(input bit ok, input string nm,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pop and compare on every handshake, check stall stability.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                if (hold_v[i]) begin
                    chk({ov[i], ot[i], ol[i], od[i]} == held[i], "hold_stable",
                        32'({ov[i], ot[i], ol[i], od[i]}), 32'(held[i]));
                end
                if (ov[i] && ready[i]) begin
                    if (sq[i].size() == 0) begin
                        chk(1'b0, "unexpected_word", 32'(od[i]), 32'hFFFFFFFF);
                    end else begin
                        exp_t e;
                        e = sq[i].pop_front();
                        chk(ot[i] == e.tag, "tag", 32'(ot[i]), 32'(e.tag));
                        chk(od[i] == e.data, "data", 32'(od[i]), 32'(e.data));
                        chk(ol[i] == e.last, "last", 32'(ol[i]), 32'(e.last));
                        if (e.tag == 2'd1)
                            chk(16'(rfa[i]) == e.addr, "rf_addr",
                                32'(rfa[i]), 32'(e.addr));
                        if (e.tag == 2'd2)
                            chk(mema[i] == e.addr, "mem_addr",
                                32'(mema[i]), 32'(e.addr));
                    end
                end
                if (ov[i] && !ready[i]) stall[i]++;
                hold_v[i] = ov[i] && !ready[i];
                held[i]   = {ov[i], ot[i], ol[i], od[i]};
            end else begin
                hold_v[i] = 1'b0;
            end
        end
    end

    task automatic load(input bit fixed);
        pc_v = fixed ? 16'h3000 : 16'($urandom);
        for (int n = 0; n < 8; n++)
            rf_m[n] = fixed ? 16'h1110 + 16'(n) : 16'($urandom);
        for (int n = 0; n < 16; n++)
            mem_m[n] = fixed ? 16'hA000 + 16'(n) : 16'($urandom);
        mem_m[16'hFFFE] = 16'($urandom);
        mem_m[16'hFFFF] = 16'($urandom);
        mem_m[16'h1234] = 16'($urandom);
    endtask

    // Reference: a dump is PC, R0..R7, then mem[base+j] for j < n.
    task automatic push_exp(input int i);
        exp_t e;
        int n = nwords[i];
        e = '{tag: 2'd0, last: 1'b0, data: pc_v, addr: 16'h0};
        sq[i].push_back(e);
        for (int j = 0; j < 8; j++) begin
            e = '{tag: 2'd1, last: (n == 0 && j == 7),
                  data: rf_m[j], addr: 16'(j)};
            sq[i].push_back(e);
        end
        for (int j = 0; j < n; j++) begin
            logic [15:0] a;
            a = bases[i] + 16'(j);
            e = '{tag: 2'd2, last: (j == n - 1), data: mem_m[a], addr: a};
            sq[i].push_back(e);
        end
    endtask

    function automatic logic pick_ready(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (mode == 1) return (k % 3) == 0;
        return 1'($urandom);
    endfunction

    task automatic run_dump(input int i, input int mode, input bit glitch);
        int k = 0;
        int s0;
        int exp_edge;
        bit seen = 0;
        bit moved = 0;
        push_exp(i);
        s0 = stall[i];
        @(posedge clk); #1;
        start[i] = 1'b1;
        ready[i] = pick_ready(mode, 0);
        @(posedge clk); #1;
        start[i] = 1'b0;
        chk(bz[i] == 1'b1, "busy_after_start", 32'(bz[i]), 32'd1);
        while (k < 4000) begin
            if (dn[i]) begin
                seen = 1;
                break;
            end
            if (i == 2 && mema[2] != 16'h1234) moved = 1;
            ready[i] = pick_ready(mode, k);
            if (glitch) begin
                if (k == 4 || k == 19) start[i] = 1'b1;
                if (k == 5 || k == 20) start[i] = 1'b0;
            end
            @(posedge clk); #1;
            k++;
        end
        start[i] = 1'b0;
        exp_edge = 2 * (9 + nwords[i]) + (stall[i] - s0);
        chk(seen, "done_timeout", 32'(k), 32'(exp_edge));
        chk(k == exp_edge, "done_edge", 32'(k), 32'(exp_edge));
        chk(bz[i] == 1'b0, "busy_at_done", 32'(bz[i]), 32'd0);
        if (i == 2) chk(!moved, "mem_addr_static", 32'(moved), 32'd0);
        @(posedge clk); #1;
        chk(dn[i] == 1'b0, "done_pulse", 32'(dn[i]), 32'd0);
        chk(sq[i].size() == 0, "words_left", 32'(sq[i].size()), 32'd0);
        ready[i] = 1'b1;
    endtask

    task automatic check_zero(input int i, input string nm);
        logic [40:0] v;
        v = {ov[i], od[i], ot[i], ol[i], bz[i], dn[i], rfa[i], mema[i]};
        chk(v == '0, nm, 32'(v), 32'd0);
    endtask

    initial begin
        nwords = '{16, 4, 0};
        bases  = '{16'h0000, 16'hFFFE, 16'h1234};
        for (int i = 0; i < 3; i++) begin
            start[i]  = 1'b0;
            ready[i]  = 1'b1;
            stall[i]  = 0;
            hold_v[i] = 1'b0;
            held[i]   = '0;
        end
        rst = 1'b0;
        load(1'b1);
        #1;
        for (int i = 0; i < 3; i++) check_zero(i, "reset_state");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        run_dump(0, 0, 1'b0);
        run_dump(0, 1, 1'b0);
        load(1'b0);
        run_dump(1, 0, 1'b0);
        run_dump(1, 2, 1'b0);
        run_dump(2, 0, 1'b0);
        run_dump(2, 1, 1'b0);
        run_dump(0, 0, 1'b1);
        run_dump(0, 2, 1'b0);

        // Reset in the middle of the RF walk.
        push_exp(0);
        @(posedge clk); #1;
        start[0] = 1'b1;
        ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_zero(0, "async_reset");
        sq[0].delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        begin
            bit idle_ok = 1;
            repeat (6) begin
                @(posedge clk); #1;
                if (bz[0] || ov[0] || dn[0]) idle_ok = 0;
            end
            chk(idle_ok, "idle_after_reset", 32'(idle_ok), 32'd1);
        end
        load(1'b0);
        run_dump(0, 0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
